// File: rtl/mux_2to1_pkg.sv
// Shared defaults for the mux_2to1 slice.
package mux_2to1_pkg;
   localparam int unsigned DEFAULT_WIDTH   = 1;
   localparam int unsigned DEFAULT_RST_VAL = 0;
endpackage

// File: rtl/mux_2to1_if.sv
// Signal bundle for a mux_2to1 data path: master drives data/select, slave returns results.
interface mux_2to1_if
   import mux_2to1_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             s;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             s_chg;

   modport master (output a, b, s, input  y, y_q, s_chg);
   modport slave  (input  a, b, s, output y, y_q, s_chg);
endinterface

// File: rtl/mux_2to1_core.sv
// Pure combinational 2:1 select; ?: keeps X-merging behaviour on an unknown select.
module mux_2to1_core
   import mux_2to1_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S,
   output logic [WIDTH-1:0] Y
);
   assign Y = S ? B : A;
endmodule

// File: rtl/mux_2to1.sv
// 2:1 mux with a registered output copy and a one-cycle strobe on registered select changes.
module mux_2to1
   import mux_2to1_pkg::*;
#(
   parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S,
   output logic [WIDTH-1:0] Y,
   input  logic             CLK,
   input  logic             RST,
   output logic [WIDTH-1:0] Y_Q,
   output logic             S_CHG
);
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] r_y_q;
   logic             r_s_q;
   logic             r_s_chg;

   mux_2to1_core #(.WIDTH(WIDTH)) u_core (
      .A (A),
      .B (B),
      .S (S),
      .Y (w_y)
   );

   // S_Q resets to 0, so a first sample of S=1 after reset raises the strobe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_y_q   <= RST_VAL;
         r_s_q   <= 1'b0;
         r_s_chg <= 1'b0;
      end else begin
         r_y_q   <= w_y;
         r_s_q   <= S;
         r_s_chg <= (S != r_s_q);
      end
   end

   assign Y     = w_y;
   assign Y_Q   = r_y_q;
   assign S_CHG = r_s_chg;
endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: truth table, reset, select strobe and scoreboarded register path.
module tb_mux_2to1;
   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst    = 1'b0;

   int checks   = 0;
   int failures = 0;

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // 8-bit instance driven through the interface
   mux_2to1_if #(.WIDTH(8)) u_if8 ();
   mux_2to1 #(.WIDTH(8)) u_dut8 (
      .A     (u_if8.a),
      .B     (u_if8.b),
      .S     (u_if8.s),
      .Y     (u_if8.y),
      .CLK   (clk),
      .RST   (rst),
      .Y_Q   (u_if8.y_q),
      .S_CHG (u_if8.s_chg)
   );

   // Same inputs, overridden reset value
   logic [7:0] y_ff, y_q_ff;
   logic       s_chg_ff;
   mux_2to1 #(.WIDTH(8), .RST_VAL(8'hFF)) u_dut_ff (
      .A     (u_if8.a),
      .B     (u_if8.b),
      .S     (u_if8.s),
      .Y     (y_ff),
      .CLK   (clk),
      .RST   (rst),
      .Y_Q   (y_q_ff),
      .S_CHG (s_chg_ff)
   );

   // Default-width instance for the truth table
   logic a1, b1, s1, y1, y_q1, s_chg1;
   mux_2to1 u_dut1 (
      .A     (a1),
      .B     (b1),
      .S     (s1),
      .Y     (y1),
      .CLK   (clk),
      .RST   (rst),
      .Y_Q   (y_q1),
      .S_CHG (s_chg1)
   );

   typedef struct {
      logic [7:0] yq;
      logic       schg;
   } exp_t;

   exp_t sb[$];
   logic model_s_q = 1'b0;

   // Records what the register stage must show after the coming edge.
   task automatic push_expect();
      exp_t e;
      e.yq      = u_if8.s ? u_if8.b : u_if8.a;
      e.schg    = (u_if8.s != model_s_q);
      model_s_q = u_if8.s;
      sb.push_back(e);
   endtask

   task automatic test_truth_table();
      logic [7:0] exp_tab;
      logic [2:0] idx;
      exp_tab = 8'b1010_1100;
      // Counting order is {S, A, B}, matching the listed expected column
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         {s1, a1, b1} = idx;
         #1;
         checks++;
         if (y1 !== exp_tab[i]) begin
            failures++;
            $display("FAIL truth_table[%0d]: actual=%b required=%b", i, y1, exp_tab[i]);
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      checks++;
      if (u_if8.y_q !== 8'h00) begin
         failures++; $display("FAIL reset_yq: actual=%h required=00", u_if8.y_q);
      end
      checks++;
      if (y_q_ff !== 8'hFF) begin
         failures++; $display("FAIL reset_yq_override: actual=%h required=ff", y_q_ff);
      end
      checks++;
      if (u_if8.s_chg !== 1'b0 || s_chg_ff !== 1'b0) begin
         failures++; $display("FAIL reset_schg: actual=%b%b required=00", u_if8.s_chg, s_chg_ff);
      end
      checks++;
      if (y_q1 !== 1'b0 || s_chg1 !== 1'b0) begin
         failures++; $display("FAIL reset_w1: actual=%b%b required=00", y_q1, s_chg1);
      end
      u_if8.a = 8'hA5; u_if8.b = 8'h3C; u_if8.s = 1'b1;
      model_s_q = 1'b0;
      #1;
      push_expect();
      rst = 1'b0;
      #2;
      clk_en = 1'b1;
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (u_if8.y_q !== e.yq) begin
         failures++; $display("FAIL release_yq: actual=%h required=%h", u_if8.y_q, e.yq);
      end
      checks++;
      if (u_if8.s_chg !== e.schg) begin
         failures++; $display("FAIL release_schg: actual=%b required=%b", u_if8.s_chg, e.schg);
      end
      checks++;
      if (y_q_ff !== 8'h3C) begin
         failures++; $display("FAIL release_yq_override: actual=%h required=3c", y_q_ff);
      end
   endtask

   task automatic test_select();
      exp_t e;
      logic [7:0] req_y;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         u_if8.s = (i == 1);
         req_y = (i == 1) ? 8'h3C : 8'hA5;
         #1;
         checks++;
         if (u_if8.y !== req_y) begin
            failures++; $display("FAIL select_y[%0d]: actual=%h required=%h", i, u_if8.y, req_y);
         end
         push_expect();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (u_if8.y_q !== e.yq || u_if8.s_chg !== e.schg) begin
            failures++;
            $display("FAIL select_reg[%0d]: actual=%h/%b required=%h/%b",
                     i, u_if8.y_q, u_if8.s_chg, e.yq, e.schg);
         end
      end
   endtask

   task automatic test_s_toggle();
      exp_t e;
      logic [3:0] s_seq;
      logic [3:0] chg_req;
      s_seq   = 4'b0110;  // bit i is S for cycle i: 0,1,1,0
      chg_req = 4'b1010;  // strobe after each cycle: -,1,0,1
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         u_if8.s = s_seq[i];
         #1;
         push_expect();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (u_if8.y_q !== e.yq) begin
            failures++; $display("FAIL toggle_yq[%0d]: actual=%h required=%h", i, u_if8.y_q, e.yq);
         end
         if (i > 0) begin
            checks++;
            if (u_if8.s_chg !== chg_req[i]) begin
               failures++;
               $display("FAIL toggle_schg[%0d]: actual=%b required=%b", i, u_if8.s_chg, chg_req[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [7:0] req_y;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         u_if8.a = 8'($urandom);
         u_if8.b = 8'($urandom);
         u_if8.s = 1'($urandom);
         req_y = u_if8.s ? u_if8.b : u_if8.a;
         #1;
         checks++;
         if (u_if8.y !== req_y || y_ff !== req_y) begin
            failures++;
            $display("FAIL b2b_y[%0d]: actual=%h/%h required=%h", i, u_if8.y, y_ff, req_y);
         end
         push_expect();
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b2b_queue[%0d]: actual=empty required=entry", i);
         end else begin
            e = sb.pop_front();
            checks++;
            if (u_if8.y_q !== e.yq || y_q_ff !== e.yq) begin
               failures++;
               $display("FAIL b2b_yq[%0d]: actual=%h/%h required=%h", i, u_if8.y_q, y_q_ff, e.yq);
            end
            checks++;
            if (u_if8.s_chg !== e.schg || s_chg_ff !== e.schg) begin
               failures++;
               $display("FAIL b2b_schg[%0d]: actual=%b/%b required=%b", i, u_if8.s_chg, s_chg_ff, e.schg);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      @(negedge clk);
      u_if8.a = 8'hA5; u_if8.b = 8'h3C; u_if8.s = 1'b1;
      #1;
      push_expect();
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (u_if8.y_q !== e.yq) begin
         failures++; $display("FAIL areset_pre_yq: actual=%h required=%h", u_if8.y_q, e.yq);
      end
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (u_if8.y_q !== 8'h00 || y_q_ff !== 8'hFF) begin
         failures++; $display("FAIL areset_yq: actual=%h/%h required=00/ff", u_if8.y_q, y_q_ff);
      end
      checks++;
      if (u_if8.s_chg !== 1'b0) begin
         failures++; $display("FAIL areset_schg: actual=%b required=0", u_if8.s_chg);
      end
      checks++;
      if (u_if8.y !== 8'h3C) begin
         failures++; $display("FAIL areset_y: actual=%h required=3c", u_if8.y);
      end
      #1;
      rst = 1'b0;
      model_s_q = 1'b0;
      push_expect();
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (u_if8.y_q !== e.yq || u_if8.s_chg !== e.schg) begin
         failures++;
         $display("FAIL areset_post: actual=%h/%b required=%h/%b", u_if8.y_q, u_if8.s_chg, e.yq, e.schg);
      end
   endtask

   task automatic test_x_select();
      @(negedge clk);
      u_if8.s = 1'bx;
      u_if8.a = 8'h5A; u_if8.b = 8'h5A;
      #1;
      checks++;
      if (u_if8.y !== 8'h5A) begin
         failures++; $display("FAIL xsel_equal: actual=%h required=5a", u_if8.y);
      end
      u_if8.a = 8'h00; u_if8.b = 8'hFF;
      #1;
      // Four-state simulators give all-X; two-state ones resolve the select to a side
      checks++;
      if (!(u_if8.y === 8'hxx || u_if8.y === 8'h00 || u_if8.y === 8'hFF)) begin
         failures++; $display("FAIL xsel_differ: actual=%h required=xx", u_if8.y);
      end
   endtask

   initial begin
      u_if8.a = '0; u_if8.b = '0; u_if8.s = 1'b0;
      a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      test_truth_table();
      test_reset();
      test_select();
      test_s_toggle();
      test_back_to_back();
      test_async_reset();
      test_x_select();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
